// File: rtl/prim_clock_mux_sel_ctrl.sv
// Select sequencer for a two-input clock mux. A switch gates the downstream clock, waits,
// flips the registered select, waits for the mux output to settle, ungates, then acks.
// Every output is a flop output.
module prim_clock_mux_sel_ctrl #(
  parameter int unsigned OffCycles    = 4,
  parameter int unsigned SettleCycles = 8,
  parameter logic        DefaultSel   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_i,
  input  logic target_sel_i,
  output logic sel_o,
  output logic clk_en_o,
  output logic busy_o,
  output logic ack_o,
  output logic err_o
);

  // The wait counter is 8 bits wide, so both wait lengths must fit in 1..255.
  if (OffCycles < 1 || OffCycles > 255) begin : gen_off_range_chk
    $error("OffCycles must be within 1..255");
  end
  if (SettleCycles < 1 || SettleCycles > 255) begin : gen_settle_range_chk
    $error("SettleCycles must be within 1..255");
  end

  localparam logic [7:0] OffLoad    = 8'(OffCycles - 1);
  localparam logic [7:0] SettleLoad = 8'(SettleCycles - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGateOff,
    StSettle,
    StAck
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_q, sel_d;
  logic       clk_en_q, clk_en_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       err_q, err_d;
  logic       err_seen_q, err_seen_d;
  logic       target_q, target_d;
  logic       req_q;

  logic accept;
  assign accept = req_i && !req_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    clk_en_d   = clk_en_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    err_seen_d = err_seen_q;
    target_d   = target_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d   = target_sel_i;
          err_seen_d = 1'b0;
          if (target_sel_i == sel_q) begin
            // Already on the requested source: acknowledge without gating.
            state_d = StAck;
            ack_d   = 1'b1;
          end else begin
            state_d  = StGateOff;
            clk_en_d = 1'b0;
            busy_d   = 1'b1;
            cnt_d    = OffLoad;
          end
        end
      end
      StGateOff: begin
        if (cnt_q == 8'd0) begin
          sel_d   = target_q;
          cnt_d   = SettleLoad;
          state_d = StSettle;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StSettle: begin
        if (cnt_q == 8'd0) begin
          clk_en_d = 1'b1;
          state_d  = StAck;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StAck: begin
        // The ack pulse lands one cycle after the clock is re-enabled; the no-switch
        // path enters here with the pulse already raised.
        if (ack_q) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          ack_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Early request drop is flagged once per transaction; the switch still completes.
    if ((state_q == StGateOff || state_q == StSettle) && !req_i && !err_seen_q) begin
      err_d      = 1'b1;
      err_seen_d = 1'b1;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      sel_q      <= DefaultSel;
      clk_en_q   <= 1'b1;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      err_seen_q <= 1'b0;
      target_q   <= DefaultSel;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      clk_en_q   <= clk_en_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      err_seen_q <= err_seen_d;
      target_q   <= target_d;
      req_q      <= req_i;
    end
  end

  assign sel_o    = sel_q;
  assign clk_en_o = clk_en_q;
  assign busy_o   = busy_q;
  assign ack_o    = ack_q;
  assign err_o    = err_q;

`ifndef SYNTHESIS
  sel_known_a: assert property (@(posedge clk_i) disable iff (rst_i) !$isunknown(sel_o));
  sel_gated_a: assert property (@(posedge clk_i) disable iff (rst_i)
    (!$past(rst_i) && $changed(sel_o)) |-> !clk_en_o);
  ack_pulse_a: assert property (@(posedge clk_i) disable iff (rst_i) ack_o |=> !ack_o);
  err_pulse_a: assert property (@(posedge clk_i) disable iff (rst_i) err_o |=> !err_o);
`endif

endmodule

// File: doc/prim_clock_mux_sel_ctrl.md
Name: prim_clock_mux_sel_ctrl

Overview:
Single-clock sequencer that drives the select input of the generic two-input clock mux. It switches clock sources safely: it gates the downstream clock, waits, flips the registered select, waits for the mux output to settle, re-enables the clock, and then acknowledges the requester. The select output is always registered and never X, including during reset. The block sits directly upstream of the clock mux and of its companion clock gate, and runs on an always-on clock.

Parameters:
OffCycles, 4, cycles clk_en_o is held low before sel_o changes (legal range 1..255)
SettleCycles, 8, cycles after the sel_o change before clk_en_o is re-asserted (legal range 1..255)
DefaultSel, 1'b0, value of sel_o out of reset

Ports:
clk_i  input  1  always-on clock
rst_i  input  1  synchronous, active-high reset
req_i  input  1  switch request, level; a rising edge starts a transaction
target_sel_i  input  1  requested mux select; sampled only at acceptance
sel_o  output  1  registered select to the clock mux
clk_en_o  output  1  enable to the downstream clock gate
busy_o  output  1  transaction in progress
ack_o  output  1  one-cycle completion pulse
err_o  output  1  one-cycle protocol-violation pulse

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: sel_o=DefaultSel, clk_en_o=1, busy_o=0, ack_o=0, err_o=0, state=IDLE, counter=0, req_q=0.
- Reset mid-transaction: the block aborts on the next edge and all outputs return to reset values. No ack_o and no err_o are produced.
- req_q is a one-cycle delayed copy of req_i.
- Acceptance: only in IDLE, when req_i=1 and req_q=0. The cycle whose edge samples this is T0. target_sel_i is latched at T0.
- FSM states: IDLE, GATE_OFF, SETTLE, ACK.
- IDLE to ACK: target equals sel_o at acceptance. No gating occurs, and ack_o=1 at T0+1.
- IDLE to GATE_OFF: target differs from sel_o. At T0+1, clk_en_o=0, busy_o=1, and the counter loads OffCycles-1.
- GATE_OFF: the counter decrements each cycle. At count 0, the next edge sets sel_o=target, loads SettleCycles-1, and moves to SETTLE. sel_o changes at T0+1+OffCycles.
- SETTLE: the counter decrements. At count 0, the next edge sets clk_en_o=1 and moves to ACK. clk_en_o rises at T0+1+OffCycles+SettleCycles.
- ACK: ack_o=1 and busy_o=1 for exactly one cycle, then IDLE. With default parameters, ack_o is at T0+2+OffCycles+SettleCycles, i.e. T0+14.
- busy_o is high from T0+1 through the ack cycle inclusive, on the switching path only. It stays 0 on the no-switch path.
- Protocol rules:
  - req_i must stay high until ack_o.
  - If req_i is sampled low while in GATE_OFF or SETTLE, err_o pulses for one cycle, once per transaction. The sequence still completes and ack_o is still issued.
  - req_i held high after ack_o is not a new request; a new transaction requires req_i low for at least one cycle.
- Invariants:
  - sel_o changes only while clk_en_o=0.
  - clk_en_o=0 for exactly OffCycles+SettleCycles cycles per switch.
  - sel_o and clk_en_o are direct flop outputs, with no combinational path from inputs.
- Counter width is 8 bits. An elaboration-time check fails if OffCycles or SettleCycles is outside 1..255.
- Assertions:
  - sel_o never unknown after reset.
  - $changed(sel_o) implies !clk_en_o.
  - ack_o and err_o are one-cycle pulses.

Test Plan:
- Reset with DefaultSel=0, then hold rst_i=1 for 3 cycles -> sel_o=0, clk_en_o=1, busy_o=ack_o=err_o=0 throughout.
- req_i rises at T0 with target_sel_i=1 (defaults) -> clk_en_o=0 over T0+1..T0+12, sel_o=1 from T0+5, clk_en_o=1 at T0+13, ack_o pulse at T0+14, busy_o high T0+1..T0+14.
- req_i rises with target_sel_i equal to current sel_o -> ack_o at T0+1, clk_en_o stays 1, sel_o unchanged, busy_o stays 0.
- req_i held high for 20 cycles after ack_o -> no second transaction; drop req_i for 1 cycle and raise it with the opposite target -> second switch completes.
- req_i dropped at T0+3 -> err_o pulse at T0+4 only, sel_o still flips at T0+5, ack_o at T0+14.
- rst_i asserted at T0+7 mid-switch -> next edge gives sel_o=DefaultSel, clk_en_o=1, busy_o=0, no ack_o; rerun with OffCycles=1, SettleCycles=1 -> sel_o flips at T0+2, ack_o at T0+4.
